// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: resolves DMA channel requests into one grant via the HRQ/HLDA bus-hold handshake
module dma_priority_arbiter #(
  parameter int NUM_CH           = 4,
  parameter int CH_W             = 2,
  parameter bit DREQ_ACTIVE_HIGH = 1'b1,
  parameter bit DACK_ACTIVE_HIGH = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskBits,
  input  logic              rotatingPriority,
  input  logic              HLDA,
  input  logic              serviceDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   activeChannel,
  output logic              channelValid
);
  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_GRANT, S_RELEASE} state_t;
  state_t            r_state;
  logic              r_hrq;
  logic              r_valid;
  logic [NUM_CH-1:0] r_gnt;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_ptr;
  logic [NUM_CH-1:0] w_eff;
  logic [CH_W-1:0]   w_ptr;
  logic [CH_W-1:0]   w_idx;
  logic [CH_W-1:0]   w_win;
  assign w_eff         = (DREQ_ACTIVE_HIGH ? DREQ : ~DREQ) & ~maskBits;
  assign w_ptr         = rotatingPriority ? r_ptr : '0;
  assign HRQ           = r_hrq;
  assign DACK          = DACK_ACTIVE_HIGH ? r_gnt : ~r_gnt;
  assign activeChannel = r_ch;
  assign channelValid  = r_valid;
  // Search from the pointer upward with wrap; scanning backwards lets the nearest request overwrite farther ones
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = CH_W'((int'(w_ptr) + k) % NUM_CH);
      if (w_eff[w_idx]) w_win = w_idx;
    end
  end
  // Hold-handshake FSM with registered grant, channel and rotating-priority pointer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_hrq   <= 1'b0;
      r_valid <= 1'b0;
      r_gnt   <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      if (!rotatingPriority) r_ptr <= '0;
      case (r_state)
        S_IDLE: if (|w_eff) begin
          r_state <= S_REQUEST;
          r_hrq   <= 1'b1;
        end
        S_REQUEST: if (HLDA) begin
          if (|w_eff) begin
            r_state <= S_GRANT;
            r_gnt   <= NUM_CH'(1) << w_win;
            r_ch    <= w_win;
            r_valid <= 1'b1;
          end else begin
            r_state <= S_RELEASE;
            r_hrq   <= 1'b0;
          end
        end
        S_GRANT: if (serviceDone || !HLDA) begin
          r_state <= S_RELEASE;
          r_hrq   <= 1'b0;
          r_gnt   <= '0;
          r_valid <= 1'b0;
          if (serviceDone && rotatingPriority) r_ptr <= CH_W'((int'(r_ch) + 1) % NUM_CH);
        end
        S_RELEASE: if (!HLDA) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed and randomized checks of the arbiter against a behavioural model
module tb_dma_priority_arbiter;
  logic       CLK = 1'b0;
  logic       RESET_N, rotatingPriority, HLDA, serviceDone;
  logic [3:0] DREQ, maskBits;
  logic       HRQ, channelValid;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  int n_checks = 0;
  int n_fail = 0;
  int m_phase, m_gnt, m_ptr;
  bit m_hrq;
  logic [3:0] seen;
  dma_priority_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .maskBits(maskBits),
    .rotatingPriority(rotatingPriority), .HLDA(HLDA), .serviceDone(serviceDone),
    .HRQ(HRQ), .DACK(DACK), .activeChannel(activeChannel), .channelValid(channelValid)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [3:0] eff, input int start);
    int order[$];
    for (int i = 0; i < 4; i++) order.push_back((start + i) % 4);
    foreach (order[j]) if (eff[order[j]]) return order[j];
    return -1;
  endfunction
  task automatic model_reset();
    m_phase = 0;
    m_gnt   = -1;
    m_ptr   = 0;
    m_hrq   = 1'b0;
  endtask
  task automatic model_edge();
    logic [3:0] eff;
    eff = DREQ & ~maskBits;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    if (!rotatingPriority) m_ptr = 0;
    case (m_phase)
      0: if (eff != 0) begin m_phase = 1; m_hrq = 1'b1; end
      1: if (HLDA) begin
        if (eff != 0) begin
          m_gnt   = pick(eff, rotatingPriority ? m_ptr : 0);
          m_phase = 2;
        end else begin
          m_hrq   = 1'b0;
          m_phase = 3;
        end
      end
      2: if (serviceDone || !HLDA) begin
        if (serviceDone && rotatingPriority) m_ptr = (m_gnt + 1) % 4;
        m_gnt   = -1;
        m_hrq   = 1'b0;
        m_phase = 3;
      end
      default: if (!HLDA) m_phase = 0;
    endcase
  endtask
  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check({tag, "_hrq"}, HRQ, m_hrq);
    check({tag, "_dack"}, DACK, m_gnt < 0 ? 0 : (1 << m_gnt));
    check({tag, "_valid"}, channelValid, m_gnt >= 0);
    if (m_gnt >= 0) check({tag, "_ch"}, activeChannel, m_gnt);
  endtask
  task automatic serve_once(input string tag, output logic [3:0] dack_seen);
    step({tag, "_req"});
    HLDA = 1'b1;
    step({tag, "_gnt"});
    dack_seen = DACK;
    serviceDone = 1'b1;
    step({tag, "_sd"});
    serviceDone = 1'b0;
    HLDA = 1'b0;
    step({tag, "_rel"});
  endtask
  initial begin
    logic [3:0] rot_exp [5];
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    RESET_N = 1'b0; DREQ = 4'b1111; maskBits = '0; rotatingPriority = 1'b0;
    HLDA = 1'b0; serviceDone = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_hrq", HRQ, 0);
    check("reset_dack", DACK, 0);
    check("reset_valid", channelValid, 0);
    RESET_N = 1'b1;
    DREQ = 4'b0100;
    step("basic_req");
    check("basic_hrq", HRQ, 1);
    step("basic_wait");
    step("basic_wait");
    HLDA = 1'b1;
    step("basic_gnt");
    check("basic_dack", DACK, 4'b0100);
    check("basic_ch", activeChannel, 2);
    serviceDone = 1'b1;
    DREQ = 4'b0000;
    step("basic_sd");
    check("basic_sd_dack", DACK, 0);
    check("basic_sd_hrq", HRQ, 0);
    serviceDone = 1'b0;
    HLDA = 1'b0;
    step("basic_rel");
    DREQ = 4'b1010;
    serve_once("fix1", seen);
    check("fix1_dack", seen, 4'b0010);
    serve_once("fix2", seen);
    check("fix2_dack", seen, 4'b0010);
    rotatingPriority = 1'b1;
    DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve_once("rot", seen);
      check($sformatf("rot%0d_dack", i), seen, rot_exp[i]);
    end
    DREQ = 4'b0001;
    maskBits = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step("mask");
      check("mask_hrq", HRQ, 0);
    end
    maskBits = 4'b0000;
    DREQ = 4'b0100;
    step("wd_req");
    DREQ = 4'b0000;
    step("wd_hold");
    check("wd_hold_hrq", HRQ, 1);
    HLDA = 1'b1;
    step("wd_hlda");
    check("wd_hrq", HRQ, 0);
    check("wd_dack", DACK, 0);
    HLDA = 1'b0;
    step("wd_rel");
    DREQ = 4'b1000;
    step("ab_req");
    HLDA = 1'b1;
    step("ab_gnt");
    check("ab_gnt_dack", DACK, 4'b1000);
    HLDA = 1'b0;
    step("ab_abort");
    check("ab_dack", DACK, 0);
    step("ab_rel");
    DREQ = 4'b1111;
    serve_once("ab_ptr", seen);
    check("ab_ptr_dack", seen, 4'b0010);
    step("rs_req");
    HLDA = 1'b1;
    step("rs_gnt");
    check("rs_gnt_valid", channelValid, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("rs_async_dack", DACK, 0);
    check("rs_async_hrq", HRQ, 0);
    check("rs_async_valid", channelValid, 0);
    HLDA = 1'b0;
    step("rs_hold");
    RESET_N = 1'b1;
    for (int i = 0; i < 800; i++) begin
      DREQ = 4'($urandom);
      maskBits = ($urandom % 4 == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom % 40 == 0) rotatingPriority = ~rotatingPriority;
      HLDA = ($urandom % 10 == 0) ? ~m_hrq : m_hrq;
      serviceDone = ($urandom % 4 == 0);
      RESET_N = ($urandom % 150 != 0);
      step("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
